// File: rtl/counter_pkg.sv
// Shared types and helpers for the BCD counter control slice:
// FSM state and modulus encodings, and BCD terminal/modulus lookups.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_10  = 2'd0,
        MODE_24  = 2'd1,
        MODE_60  = 2'd2,
        MODE_100 = 2'd3
    } mode_t;

    // Last value shown before the counter wraps to 00.
    function automatic logic [7:0] terminal_bcd(input mode_t m);
        logic [7:0] t;
        unique case (m)
            MODE_10:  t = 8'h09;
            MODE_24:  t = 8'h23;
            MODE_60:  t = 8'h59;
            MODE_100: t = 8'h99;
        endcase
        return t;
    endfunction

    // Modulus in BCD; 100 does not fit two digits, so it is encoded as 00.
    function automatic logic [7:0] modulus_bcd(input mode_t m);
        logic [7:0] r;
        unique case (m)
            MODE_10:  r = 8'h10;
            MODE_24:  r = 8'h24;
            MODE_60:  r = 8'h60;
            MODE_100: r = 8'h00;
        endcase
        return r;
    endfunction

    // Valid BCD compares correctly as plain binary, so >= works digit-wise.
    function automatic logic count_out_of_range(input logic [7:0] count, input mode_t m);
        logic [7:0] lim;
        lim = modulus_bcd(m);
        return (lim != 8'h00) && (count >= lim);
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Control <-> datapath bundle: count actions and status out, BCD digits back.
interface counter_ctrl_if;

    logic       inc;
    logic       clr;
    logic [1:0] mode;
    logic [1:0] state;
    logic [3:0] cnt_ones;
    logic [3:0] cnt_tens;

    modport master (
        output inc, clr, mode, state,
        input  cnt_ones, cnt_tens
    );

    modport slave (
        input  inc, clr, mode, state,
        output cnt_ones, cnt_tens
    );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse when an active-low press is accepted.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // Synchronise, count identical samples that differ from the accepted level, accept on the last one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n};
            press_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                press_q  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Control/sequencing for the two-digit BCD counter: button debounce,
// start/hold/stop FSM, count tick divider and modulus selection.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned PERIOD          = 1500000,
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned RESET_MODE      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start_n,
    input  logic btn_mode_n,
    input  logic btn_clear_n,
    counter_ctrl_if.master dp
);

    localparam int unsigned      DIV_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);
    localparam mode_t            RST_MODE = mode_t'(RESET_MODE[1:0]);

    logic start_p, mode_p, clear_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_start_n),
        .press (start_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_mode_n),
        .press (mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_clear_n),
        .press (clear_p)
    );

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             inc_q, inc_d;
    logic             clr_q, clr_d;
    logic             tick;
    logic [7:0]       count;

    assign count = {dp.cnt_tens, dp.cnt_ones};
    assign tick  = (state_q == ST_RUN) && (div_q == DIV_LAST);

    // Register FSM state, modulus, divider and the one-cycle count actions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_STOP;
            mode_q  <= RST_MODE;
            div_q   <= '0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
        end
    end

    // Resolve coincident events (clear > mode > start > tick) into next state and action.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = '0;
        inc_d   = 1'b0;
        clr_d   = 1'b0;

        if (clear_p) begin
            state_d = ST_STOP;
            clr_d   = 1'b1;
        end else if (mode_p) begin
            mode_d = mode_t'(mode_q + 2'd1);
            clr_d  = count_out_of_range(count, mode_d);
        end else if (start_p) begin
            case (state_q)
                ST_STOP: state_d = ST_RUN;
                ST_RUN:  state_d = ST_HOLD;
                ST_HOLD: state_d = ST_RUN;
                default: state_d = ST_STOP;
            endcase
        end else if (tick) begin
            if (count == terminal_bcd(mode_q)) begin
                clr_d = 1'b1;
            end else begin
                inc_d = 1'b1;
            end
        end

        // Divider idles at 0 outside RUN, which also gives the zero start on each entry.
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && (div_q != DIV_LAST)) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    assign dp.inc   = inc_q;
    assign dp.clr   = clr_q;
    assign dp.mode  = mode_q;
    assign dp.state = state_q;

endmodule
